// File: rtl/vip_pkg.sv
// vip_pkg: shared constants for the video pre-processing chain.
package vip_pkg;
    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int COEF_R     = 77;
    localparam int COEF_G     = 150;
    localparam int COEF_B     = 29;
    localparam int COEF_SHIFT = 8;
    localparam int R_MSB      = 15;
    localparam int R_LSB      = 11;
    localparam int G_MSB      = 10;
    localparam int G_LSB      = 5;
    localparam int B_MSB      = 4;
    localparam int B_LSB      = 0;
endpackage

// File: rtl/vip_sync_delay.sv
// vip_sync_delay: fixed-depth shift register for a bundle of frame sync strobes.
module vip_sync_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH*WIDTH-1:0] sr_q, sr_d;
    always_comb begin
        sr_d = (sr_q << WIDTH) | (DEPTH*WIDTH)'(din);
        dout = sr_q[DEPTH*WIDTH-1 -: WIDTH];
    end
    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end
endmodule

// File: rtl/vip_rgb565_gray_convert.sv
// vip_rgb565_gray_convert: RGB565 to 8-bit luma with aligned pixel coordinates
// and line/frame geometry checking, fixed 3-cycle latency.
module vip_rgb565_gray_convert
    import vip_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pre_frame_vsync,
    input  logic          pre_frame_href,
    input  logic          pre_frame_clken,
    input  logic [15:0]   pre_img_rgb565,
    output logic          post_frame_vsync,
    output logic          post_frame_href,
    output logic          post_frame_clken,
    output logic [7:0]    post_img_Y,
    output logic [XW-1:0] post_x,
    output logic [YW-1:0] post_y,
    output logic          frame_done,
    output logic          line_err
);
    localparam logic [XW:0]   W_LEN = (XW+1)'(IMG_W);
    localparam logic [XW:0]   W_SAT = (XW+1)'(IMG_W + 1);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW:0]   H_LEN = (YW+1)'(IMG_H);
    localparam logic [YW:0]   H_SAT = (YW+1)'(IMG_H + 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    logic [7:0]         r8, g8, b8;
    logic [15:0]        pr_q, pr_d, pg_q, pg_d, pb_q, pb_d, sum_q, sum_d;
    logic [7:0]         luma_q, luma_d;
    logic [2:0][XW-1:0] px_q, px_d;
    logic [2:0][YW-1:0] py_q, py_d;
    logic [XW:0]        pix_cnt_q, pix_cnt_d;
    logic [YW:0]        line_cnt_q, line_cnt_d, line_tot;
    logic               vs_prev_q, vs_prev_d, hs_prev_q, hs_prev_d, armed_q, armed_d;
    logic               line_err_q, line_err_d, av_prev_q, av_prev_d, frame_done_q, frame_done_d;
    logic               vs_rise, vs_fall, hs_fall, av, av_post;
    logic [XW-1:0]      x_cur;
    logic [YW-1:0]      y_cur;

    // av marks vsync of frames that began after arming; it rides the sync
    // pipeline so frame_done ignores frames already running at reset release.
    vip_sync_delay #(.DEPTH(3), .WIDTH(4)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  ({av, pre_frame_vsync, pre_frame_href, pre_frame_clken}),
        .dout ({av_post, post_frame_vsync, post_frame_href, post_frame_clken})
    );

    always_comb begin
        r8 = {pre_img_rgb565[R_MSB:R_LSB], pre_img_rgb565[R_MSB -: 3]};
        g8 = {pre_img_rgb565[G_MSB:G_LSB], pre_img_rgb565[G_MSB -: 2]};
        b8 = {pre_img_rgb565[B_MSB:B_LSB], pre_img_rgb565[B_MSB -: 3]};
        pr_d = 16'(COEF_R * r8);
        pg_d = 16'(COEF_G * g8);
        pb_d = 16'(COEF_B * b8);
        sum_d = pr_q + pg_q + pb_q;
        luma_d = 8'(sum_q >> COEF_SHIFT);
        vs_rise = pre_frame_vsync & ~vs_prev_q;
        vs_fall = armed_q & vs_prev_q & ~pre_frame_vsync;
        hs_fall = armed_q & vs_prev_q & hs_prev_q & ~pre_frame_href;
        av = pre_frame_vsync & (armed_q | vs_rise);
        armed_d = armed_q | vs_rise;
        vs_prev_d = pre_frame_vsync;
        hs_prev_d = pre_frame_href;
        pix_cnt_d = !pre_frame_href ? '0 :
                    (pre_frame_clken && av && pix_cnt_q != W_SAT) ? pix_cnt_q + 1'b1 : pix_cnt_q;
        line_cnt_d = vs_rise ? '0 : (hs_fall && line_cnt_q != H_SAT) ? line_cnt_q + 1'b1 : line_cnt_q;
        // a line ending together with vsync still counts toward the frame total
        line_tot = line_cnt_q + {{YW{1'b0}}, hs_fall};
        line_err_d = line_err_q | (hs_fall && pix_cnt_q != W_LEN) | (vs_fall && line_tot != H_LEN);
        x_cur = pix_cnt_q >= W_LEN ? X_MAX : pix_cnt_q[XW-1:0];
        y_cur = vs_rise ? '0 : line_cnt_q >= H_LEN ? Y_MAX : line_cnt_q[YW-1:0];
        px_d = {px_q[1:0], x_cur};
        py_d = {py_q[1:0], y_cur};
        av_prev_d = av_post;
        frame_done_d = av_prev_q & ~av_post;
        post_img_Y = post_frame_href ? luma_q : 8'd0;
        post_x = px_q[2];
        post_y = py_q[2];
        frame_done = frame_done_q;
        line_err = line_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pr_q         <= '0;
            pg_q         <= '0;
            pb_q         <= '0;
            sum_q        <= '0;
            luma_q       <= '0;
            px_q         <= '0;
            py_q         <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            vs_prev_q    <= 1'b1; // no rising edge can be seen while vsync is already high at release
            hs_prev_q    <= 1'b0;
            armed_q      <= 1'b0;
            line_err_q   <= 1'b0;
            av_prev_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pr_q         <= pr_d;
            pg_q         <= pg_d;
            pb_q         <= pb_d;
            sum_q        <= sum_d;
            luma_q       <= luma_d;
            px_q         <= px_d;
            py_q         <= py_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            vs_prev_q    <= vs_prev_d;
            hs_prev_q    <= hs_prev_d;
            armed_q      <= armed_d;
            line_err_q   <= line_err_d;
            av_prev_q    <= av_prev_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule
